// File: rtl/iterative_shifter.sv
// iterative_shifter
//   Multi-cycle shifter that moves the operand by at most STEP bits per
//   clock until the requested amount has been applied.
//
//   Optional feature macro: SHIFTER_ABORT_EN (adds the abort input).
//
//   Ports
//     clk      in   rising-edge clock
//     clr      in   synchronous active-low reset
//     start    in   begin an operation (sampled only in IDLE)
//     op_code  in   01001 SHR, 01010 SHRA, 01011 SHL, 01100 ROR, 01101 ROL
//     a        in   operand
//     b        in   shift amount, only b[AW-1:0] used
//     abort    in   (SHIFTER_ABORT_EN only) drop the operation while in SHIFT
//     result   out  shifted value, held until the next accepted start
//     busy     out  high in SHIFT and DONE
//     done     out  one-cycle completion pulse
//     err      out  illegal op_code seen, held until the next accepted start
//
//   state | meaning
//   IDLE  | waiting for start
//   SHIFT | applying up to STEP bits per clock
//   DONE  | one-cycle completion, always returns to IDLE
module iterative_shifter #(
  parameter int WIDTH = 32,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [4:0]       op_code,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SHIFTER_ABORT_EN
  input  logic             abort,
`endif
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int AW = $clog2(WIDTH);
  localparam logic [AW-1:0] STEP_AMT = AW'(STEP);

  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ROR  = 5'b01100;
  localparam logic [4:0] OP_ROL  = 5'b01101;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [AW-1:0]    rem_q, rem_d;
  logic [4:0]       op_q, op_d;
  logic             sign_q, sign_d;
  logic             err_q, err_d;

  logic [AW-1:0]    step_amt;
  logic [AW-1:0]    amt_in;
  logic             op_legal;
  logic [WIDTH-1:0] shifted;
  logic [2*WIDTH-1:0] dbl;

  // Upper bits of b are intentionally ignored.
  logic unused_b_hi;
  assign unused_b_hi = ^b[WIDTH-1:AW];

  assign amt_in   = b[AW-1:0];
  assign op_legal = (op_code == OP_SHR) || (op_code == OP_SHRA) ||
                    (op_code == OP_SHL) || (op_code == OP_ROR)  ||
                    (op_code == OP_ROL);

  // One step of the shift; rotations and the arithmetic fill use a
  // double-width word so a single shifter covers all five operations.
  always_comb begin
    step_amt = (rem_q < STEP_AMT) ? rem_q : STEP_AMT;
    dbl      = '0;
    shifted  = result_q;
    case (op_q)
      OP_SHR:  shifted = result_q >> step_amt;
      OP_SHRA: begin
        dbl     = {{WIDTH{sign_q}}, result_q} >> step_amt;
        shifted = dbl[WIDTH-1:0];
      end
      OP_SHL:  shifted = result_q << step_amt;
      OP_ROR: begin
        dbl     = {result_q, result_q} >> step_amt;
        shifted = dbl[WIDTH-1:0];
      end
      OP_ROL: begin
        dbl     = {result_q, result_q} << step_amt;
        shifted = dbl[2*WIDTH-1:WIDTH];
      end
      default: shifted = result_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    rem_d    = rem_q;
    op_d     = op_q;
    sign_d   = sign_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          result_d = a;
          op_d     = op_code;
          sign_d   = a[WIDTH-1];
          err_d    = !op_legal;
          if (op_legal && (amt_in != '0)) begin
            rem_d   = amt_in;
            state_d = S_SHIFT;
          end else begin
            rem_d   = '0;
            state_d = S_DONE;
          end
        end
      end
      S_SHIFT: begin
        result_d = shifted;
        rem_d    = rem_q - step_amt;
        if (rem_d == '0) state_d = S_DONE;
`ifdef SHIFTER_ABORT_EN
        // The step on the abort edge still lands; only completion is dropped.
        if (abort) begin
          rem_d   = '0;
          state_d = S_IDLE;
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      rem_q    <= '0;
      op_q     <= '0;
      sign_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      op_q     <= op_d;
      sign_q   <= sign_d;
      err_q    <= err_d;
    end
  end

  assign result = result_q;
  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign err    = err_q;

endmodule

// File: tb/tb_iterative_shifter.sv
module tb_iterative_shifter;

  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_ROR  = 5'b01100;
  localparam logic [4:0] OP_ROL  = 5'b01101;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  op_code = 5'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        abort = 1'b0;

  logic [31:0] result1, result4;
  logic        busy1, busy4, done1, done4, err1, err4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iterative_shifter #(.WIDTH(32), .STEP(1)) dut1 (
    .clk(clk), .clr(clr), .start(start), .op_code(op_code), .a(a), .b(b),
`ifdef SHIFTER_ABORT_EN
    .abort(abort),
`endif
    .result(result1), .busy(busy1), .done(done1), .err(err1)
  );

  iterative_shifter #(.WIDTH(32), .STEP(4)) dut4 (
    .clk(clk), .clr(clr), .start(start), .op_code(op_code), .a(a), .b(b),
`ifdef SHIFTER_ABORT_EN
    .abort(1'b0),
`endif
    .result(result4), .busy(busy4), .done(done4), .err(err4)
  );

  // Issues one start and reports the done latency (edges after the sampling
  // edge) and the number of done pulses seen; lat = -1 means no done.
  task automatic do_op(input int sel, input logic [4:0] o, input logic [31:0] av,
                       input logic [31:0] bv, output int lat, output int pulses);
    logic d;
    @(negedge clk);
    clr = 1'b1; start = 1'b1; op_code = o; a = av; b = bv;
    @(posedge clk);
    #1 start = 1'b0;
    lat = -1;
    pulses = 0;
    for (int n = 0; n < 80; n++) begin
      @(negedge clk);
      d = (sel == 0) ? done1 : done4;
      if (d) begin
        pulses++;
        if (lat < 0) lat = n;
      end else if (lat >= 0 && n > lat + 3) begin
        break;
      end
    end
  endtask

  task automatic test_reset();
    clr = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (result1 !== 32'h0) begin errors++; $display("FAIL reset_result got %h exp %h", result1, 32'h0); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy1); end
    checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done1); end
    checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err1); end
  endtask

  // Start arrives on the very first edge with clr released.
  task automatic test_shr();
    int lat, p;
    do_op(0, OP_SHR, 32'h0000_0008, 32'd2, lat, p);
    checks++; if (result1 !== 32'h0000_0002) begin errors++; $display("FAIL shr_result got %h exp %h", result1, 32'h2); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL shr_latency got %0d exp 2", lat); end
    checks++; if (p !== 1) begin errors++; $display("FAIL shr_pulses got %0d exp 1", p); end
    checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL shr_err got %b exp 0", err1); end
  endtask

  task automatic test_ops();
    int lat, p;
    do_op(0, OP_SHRA, 32'h8000_0000, 32'd4, lat, p);
    checks++; if (result1 !== 32'hF800_0000) begin errors++; $display("FAIL shra_result got %h exp %h", result1, 32'hF8000000); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL shra_latency got %0d exp 4", lat); end
    do_op(0, OP_ROL, 32'h8000_0001, 32'd1, lat, p);
    checks++; if (result1 !== 32'h0000_0003) begin errors++; $display("FAIL rol_result got %h exp %h", result1, 32'h3); end
    do_op(0, OP_ROR, 32'h0000_0001, 32'd1, lat, p);
    checks++; if (result1 !== 32'h8000_0000) begin errors++; $display("FAIL ror_result got %h exp %h", result1, 32'h80000000); end
    do_op(0, OP_SHL, 32'h0000_0001, 32'd31, lat, p);
    checks++; if (result1 !== 32'h8000_0000) begin errors++; $display("FAIL shl31_result got %h exp %h", result1, 32'h80000000); end
    checks++; if (lat !== 31) begin errors++; $display("FAIL shl31_latency got %0d exp 31", lat); end
    checks++; if (p !== 1) begin errors++; $display("FAIL shl31_pulses got %0d exp 1", p); end
  endtask

  task automatic test_zero_amt();
    int lat, p;
    do_op(0, OP_SHR, 32'h0000_1234, 32'd0, lat, p);
    checks++; if (result1 !== 32'h0000_1234) begin errors++; $display("FAIL zero_result got %h exp %h", result1, 32'h1234); end
    checks++; if (lat !== 0) begin errors++; $display("FAIL zero_latency got %0d exp 0", lat); end
    // Only b[4:0] counts, so 32 is a zero shift.
    do_op(0, OP_SHL, 32'hA5A5_0001, 32'd32, lat, p);
    checks++; if (result1 !== 32'hA5A5_0001) begin errors++; $display("FAIL bmask_result got %h exp %h", result1, 32'hA5A50001); end
    checks++; if (lat !== 0) begin errors++; $display("FAIL bmask_latency got %0d exp 0", lat); end
  endtask

  task automatic test_illegal();
    int lat, p;
    do_op(0, 5'b11111, 32'hDEAD_BEEF, 32'd5, lat, p);
    checks++; if (result1 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL illegal_result got %h exp %h", result1, 32'hDEADBEEF); end
    checks++; if (lat !== 0) begin errors++; $display("FAIL illegal_latency got %0d exp 0", lat); end
    checks++; if (p !== 1) begin errors++; $display("FAIL illegal_pulses got %0d exp 1", p); end
    repeat (3) @(negedge clk);
    checks++; if (err1 !== 1'b1) begin errors++; $display("FAIL illegal_err_held got %b exp 1", err1); end
    do_op(0, OP_SHL, 32'h0000_0003, 32'd1, lat, p);
    checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL err_cleared got %b exp 0", err1); end
    checks++; if (result1 !== 32'h0000_0006) begin errors++; $display("FAIL shl1_result got %h exp %h", result1, 32'h6); end
  endtask

  task automatic test_hold();
    a = 32'h5555_5555; b = 32'd7; op_code = OP_ROL;
    repeat (5) @(negedge clk);
    checks++; if (result1 !== 32'h0000_0006) begin errors++; $display("FAIL hold_result got %h exp %h", result1, 32'h6); end
  endtask

  // start stays high and inputs change throughout SHIFT; neither may disturb the op.
  task automatic test_back_to_back();
    int p = 0;
    int seen = 0;
    @(negedge clk);
    clr = 1'b1; start = 1'b1; op_code = OP_SHR; a = 32'h0000_00F0; b = 32'd4;
    @(posedge clk);
    #1 a = 32'hFFFF_FFFF; b = 32'd1; op_code = OP_SHL;
    for (int n = 0; n < 20 && seen == 0; n++) begin
      @(negedge clk);
      if (done1) begin p++; seen = 1; start = 1'b0; end
    end
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (done1) p++;
    end
    checks++; if (result1 !== 32'h0000_000F) begin errors++; $display("FAIL b2b_result got %h exp %h", result1, 32'hF); end
    checks++; if (p !== 1) begin errors++; $display("FAIL b2b_pulses got %0d exp 1", p); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL b2b_idle_busy got %b exp 0", busy1); end
  endtask

  task automatic test_mid_reset();
    int lat, p;
    int pulses = 0;
    @(negedge clk);
    clr = 1'b1; start = 1'b1; op_code = OP_SHR; a = 32'hFFFF_FFFF; b = 32'd20;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    checks++; if (result1 !== 32'h0) begin errors++; $display("FAIL midrst_result got %h exp 0", result1); end
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b exp 0", busy1); end
    checks++; if (done1 !== 1'b0) begin errors++; $display("FAIL midrst_done got %b exp 0", done1); end
    clr = 1'b1;
    for (int n = 0; n < 25; n++) begin
      @(negedge clk);
      if (done1) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_no_done got %0d exp 0", pulses); end
    do_op(0, OP_SHR, 32'h0000_0100, 32'd8, lat, p);
    checks++; if (result1 !== 32'h0000_0001) begin errors++; $display("FAIL post_rst_result got %h exp %h", result1, 32'h1); end
    checks++; if (lat !== 8) begin errors++; $display("FAIL post_rst_latency got %0d exp 8", lat); end
  endtask

`ifdef SHIFTER_ABORT_EN
  task automatic test_abort();
    int pulses = 0;
    @(negedge clk);
    clr = 1'b1; start = 1'b1; op_code = OP_SHL; a = 32'h0000_0001; b = 32'd10;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy1); end
    checks++; if (result1 !== 32'h0000_0004) begin errors++; $display("FAIL abort_result got %h exp %h", result1, 32'h4); end
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (done1) pulses++;
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_no_done got %0d exp 0", pulses); end
  endtask
`endif

  task automatic test_step4();
    int lat, p;
    repeat (40) @(negedge clk);
    do_op(1, OP_SHL, 32'h0000_0001, 32'd31, lat, p);
    checks++; if (result4 !== 32'h8000_0000) begin errors++; $display("FAIL step4_shl_result got %h exp %h", result4, 32'h80000000); end
    checks++; if (lat !== 8) begin errors++; $display("FAIL step4_shl_latency got %0d exp 8", lat); end
    checks++; if (p !== 1) begin errors++; $display("FAIL step4_shl_pulses got %0d exp 1", p); end
    repeat (40) @(negedge clk);
    do_op(1, OP_ROR, 32'h0000_0001, 32'd5, lat, p);
    checks++; if (result4 !== 32'h0800_0000) begin errors++; $display("FAIL step4_ror_result got %h exp %h", result4, 32'h08000000); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL step4_ror_latency got %0d exp 2", lat); end
  endtask

  initial begin
    test_reset();
    test_shr();
    test_ops();
    test_zero_amt();
    test_illegal();
    test_hold();
    test_back_to_back();
    test_mid_reset();
`ifdef SHIFTER_ABORT_EN
    test_abort();
`endif
    test_step4();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/iterative_shifter.md
ITERATIVE_SHIFTER -- requirements
Module: iterative_shifter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset; all state SHALL update on the rising edge of clk only.
REQ-002 Parameter WIDTH SHALL default to 32 and set the operand and result width (legal values are 8, 16, 32 or 64).
REQ-003 Parameter STEP SHALL default to 1 and set the maximum bits shifted per clock (a power of two, 1..WIDTH/2).
REQ-004 Local parameter AW SHALL equal clog2(WIDTH) and set the shift-amount width.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 clr  input  1  synchronous active-low reset.
REQ-007 start  input  1  request to begin an operation; sampled only in IDLE.
REQ-008 op_code  input  5  operation: 01001 SHR, 01010 SHRA, 01011 SHL, 01100 ROR, 01101 ROL.
REQ-009 a  input  WIDTH  operand to shift.
REQ-010 b  input  WIDTH  shift amount; only b[AW-1:0] is used.
REQ-011 result  output  WIDTH  shifted value.
REQ-012 busy  output  1  high in SHIFT and DONE.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 err  output  1  set when op_code is illegal; held until the next accepted start.

Function
REQ-015 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-016 IDLE with start=1 SHALL latch a, op_code and amt=b[AW-1:0], clear err, and transfer as follows:
- to SHIFT if amt is nonzero and op_code is legal;
- otherwise to DONE.
REQ-017 In each SHIFT cycle, result SHALL shift by s=min(STEP, remaining) and remaining SHALL decrease by s.
REQ-018 When remaining reaches 0, the FSM SHALL go from SHIFT to DONE.
REQ-019 SHR SHALL fill vacated bits with 0; SHRA SHALL fill with the latched a[WIDTH-1]; SHL SHALL fill with 0; ROR and ROL SHALL rotate.
REQ-020 DONE SHALL assert done for exactly one cycle and SHALL transition to IDLE unconditionally.
REQ-021 done SHALL be high in the cycle beginning ceil(amt/STEP) clocks after the edge that samples start; amt=0 gives 0 clocks.
REQ-022 An illegal op_code SHALL produce result=a, err=1 and the same one-cycle DONE path.
REQ-023 start while busy=1 SHALL be ignored, with no queuing.
REQ-024 result SHALL hold its value after DONE until the next accepted start.
REQ-025 amt=WIDTH-1 SHALL complete without wrap.
REQ-026 Inputs a, b and op_code changing during SHIFT SHALL have no effect on the operation in progress.

Reset
REQ-027 clr=0 at a rising edge SHALL force state=IDLE, result=0, remaining=0, busy=0, done=0 and err=0.
REQ-028 Reset mid-operation SHALL discard the operation with no done pulse.
REQ-029 start SHALL be honoured on the first edge with clr=1.

Configuration
REQ-030 With SHIFTER_ABORT_EN defined, the block SHALL add input abort (1 bit); abort=1 in SHIFT SHALL go to IDLE on the next edge with no done pulse, leaving result at its partial value.
REQ-031 With SHIFTER_ABORT_EN defined, abort SHALL have no effect in IDLE or DONE.
REQ-032 Without SHIFTER_ABORT_EN, the abort port SHALL be absent and every accepted start SHALL end in DONE.

Verification
REQ-033 WIDTH=32, STEP=1, SHR a=0x00000008 b=2 -> result=0x00000002, done high in the 2nd cycle after start is sampled, err=0.
REQ-034 SHRA a=0x80000000 b=4 -> 0xF8000000; ROL a=0x80000001 b=1 -> 0x00000003; ROR a=0x00000001 b=1 -> 0x80000000.
REQ-035 STEP=4, SHL a=0x00000001 b=31 -> 0x80000000 after 8 SHIFT cycles, with exactly one done pulse.
REQ-036 b=0 -> result=a and done on the cycle after sampling; op_code=11111 -> result=a, err=1; start held high during SHIFT starts no second operation.
REQ-037 clr=0 asserted in the 3rd SHIFT cycle of SHR b=20 -> all outputs 0 on the next edge and no done pulse; a new start after release completes normally.
REQ-038 With SHIFTER_ABORT_EN, abort in the 2nd SHIFT cycle of SHL a=0x1 b=10 -> IDLE next edge, busy=0, no done, result=0x00000004.
